// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants and state encoding for the GMII transmit framer.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    FCS,
    IFG,
    DROP
  } tx_state_t;

endpackage

// File: rtl/gmii_tx_framer_crc32_d8.sv
// Byte-wide reflected CRC-32 next-state function (crc32_d8).
// Only compiled when GMII_TX_FCS_EN is defined, since it is unused otherwise.
`ifdef GMII_TX_FCS_EN
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  // Fold the byte in LSB first, one polynomial division step per bit.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h000000, d};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule
`endif

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: pops frames from a FWFT FIFO and emits
// preamble, SFD, payload (and FCS when GMII_TX_FCS_EN is defined),
// followed by the inter-frame gap. Underrun truncates the frame.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       gmii_gtx_clk,
  input  logic       sys_rst,
  input  logic       frm_empty,
  input  logic [7:0] frm_dout,
  input  logic       frm_last,
  output logic       frm_rd_en,
  output logic       fifo_dv,
  output logic [7:0] fifo_din,
  output logic       tx_underrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_t  state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       dv_nx;
  logic [7:0] din_nx;
  logic       und_nx;

`ifdef GMII_TX_FCS_EN
  logic [31:0] crc, crc_nx, crc_upd, fcs_word;

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc),
    .d       (frm_dout),
    .crc_out (crc_upd)
  );

  assign fcs_word = ~crc;
`endif

  // The FIFO is only popped while a frame body is being sent or dropped.
  assign frm_rd_en = ((state == DATA) || (state == DROP)) && !frm_empty;

  // Next-state and next-output decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dv_nx    = 1'b0;
    din_nx   = 8'h00;
    und_nx   = 1'b0;
`ifdef GMII_TX_FCS_EN
    crc_nx   = crc;
`endif
    case (state)
      IDLE: begin
        if (!frm_empty) begin
          state_nx = PRE;
          dv_nx    = 1'b1;
          din_nx   = PREAMBLE_BYTE;
          cnt_nx   = 8'd1;
`ifdef GMII_TX_FCS_EN
          crc_nx   = CRC32_INIT;
`endif
        end
      end
      PRE: begin
        dv_nx = 1'b1;
        if (cnt == PRE_LAST) begin
          din_nx   = SFD_BYTE;
          state_nx = DATA;
          cnt_nx   = '0;
        end else begin
          din_nx = PREAMBLE_BYTE;
          cnt_nx = cnt + 8'd1;
        end
      end
      DATA: begin
        if (!frm_empty) begin
          dv_nx  = 1'b1;
          din_nx = frm_dout;
`ifdef GMII_TX_FCS_EN
          crc_nx = crc_upd;
          if (frm_last) begin
            state_nx = FCS;
            cnt_nx   = '0;
          end
`else
          if (frm_last) begin
            state_nx = IFG;
            cnt_nx   = '0;
          end
`endif
        end else begin
          und_nx   = 1'b1;
          state_nx = DROP;
        end
      end
`ifdef GMII_TX_FCS_EN
      FCS: begin
        dv_nx  = 1'b1;
        din_nx = fcs_word[{cnt[1:0], 3'b000} +: 8];
        if (cnt[1:0] == 2'd3) begin
          state_nx = IFG;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
`endif
      DROP: begin
        if (!frm_empty && frm_last) begin
          state_nx = IFG;
          cnt_nx   = '0;
        end
      end
      IFG: begin
        // The gap is counted only over cycles where dv is already low, so a
        // normal frame end spends one extra IFG cycle retiring its last byte.
        if (!fifo_dv) begin
          if (cnt == IFG_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and registered GMII-side outputs.
  always_ff @(posedge gmii_gtx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      fifo_dv     <= 1'b0;
      fifo_din    <= 8'h00;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      fifo_dv     <= dv_nx;
      fifo_din    <= din_nx;
      tx_underrun <= und_nx;
    end
  end

`ifdef GMII_TX_FCS_EN
  // Running CRC over emitted payload bytes.
  always_ff @(posedge gmii_gtx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      crc <= '0;
    end else begin
      crc <= crc_nx;
    end
  end
`endif

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer (honours GMII_TX_FCS_EN).
module tb_gmii_tx_framer;
  import gmii_pkg::*;

  localparam int unsigned PRE_N = 7;
  localparam int unsigned IFG_N = 12;

  logic       gmii_gtx_clk = 1'b0;
  logic       sys_rst      = 1'b0;
  logic       frm_empty    = 1'b1;
  logic [7:0] frm_dout     = 8'h00;
  logic       frm_last     = 1'b0;
  logic       frm_rd_en;
  logic       fifo_dv;
  logic [7:0] fifo_din;
  logic       tx_underrun;

  gmii_tx_framer #(.PREAMBLE_LEN(PRE_N), .IFG_BYTES(IFG_N)) dut (
    .gmii_gtx_clk (gmii_gtx_clk),
    .sys_rst      (sys_rst),
    .frm_empty    (frm_empty),
    .frm_dout     (frm_dout),
    .frm_last     (frm_last),
    .frm_rd_en    (frm_rd_en),
    .fifo_dv      (fifo_dv),
    .fifo_din     (fifo_din),
    .tx_underrun  (tx_underrun)
  );

  always #4 gmii_gtx_clk = ~gmii_gtx_clk;

  // FIFO contents and stall control, owned by the stimulus process.
  logic [7:0] q_data[$];
  bit         q_last[$];
  bit         stall;

  // Monitor state.
  logic [7:0] cap[$];
  int         gaps[$];
  int         low_run;
  bit         seen_high;
  int         und_cnt;

  int tests = 0;
  int fails = 0;

  // Model outputs: what the DUT must show after the most recent edge.
  logic       exp_dv  = 1'b0;
  logic [7:0] exp_din = 8'h00;
  logic       exp_und = 1'b0;
  bit         m_pop   = 1'b0;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    bit fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ CRC32_POLY;
    end
    return r;
  endfunction

  // ---------------- behavioural reference model ----------------
  task automatic set_exp(input logic dv, input logic [7:0] d, input logic u);
    exp_dv  = dv;
    exp_din = d;
    exp_und = u;
  endtask

  // Follows one frame on the wire; returns early if reset is seen at an edge.
  task automatic model_frame();
    logic [31:0] crc;
    logic [31:0] fcs;
    bit truncated;
    int gap;
    forever begin
      @(posedge gmii_gtx_clk);
      if (sys_rst) return;
      if (!frm_empty) break;
      set_exp(1'b0, 8'h00, 1'b0);
    end
    set_exp(1'b1, PREAMBLE_BYTE, 1'b0);
    for (int i = 1; i < int'(PRE_N); i++) begin
      @(posedge gmii_gtx_clk);
      if (sys_rst) return;
      set_exp(1'b1, PREAMBLE_BYTE, 1'b0);
    end
    @(posedge gmii_gtx_clk);
    if (sys_rst) return;
    set_exp(1'b1, SFD_BYTE, 1'b0);
    m_pop = 1'b1;
    crc = CRC32_INIT;
    truncated = 1'b0;
    forever begin
      @(posedge gmii_gtx_clk);
      if (sys_rst) return;
      if (frm_empty) begin
        set_exp(1'b0, 8'h00, 1'b1);
        truncated = 1'b1;
        break;
      end
      set_exp(1'b1, frm_dout, 1'b0);
      crc = crc_byte(crc, frm_dout);
      if (frm_last) begin
        m_pop = 1'b0;
        break;
      end
    end
    if (truncated) begin
      forever begin
        @(posedge gmii_gtx_clk);
        if (sys_rst) return;
        set_exp(1'b0, 8'h00, 1'b0);
        if (!frm_empty && frm_last) begin
          m_pop = 1'b0;
          break;
        end
      end
      gap = int'(IFG_N);
    end else begin
`ifdef GMII_TX_FCS_EN
      fcs = ~crc;
      for (int k = 0; k < 4; k++) begin
        @(posedge gmii_gtx_clk);
        if (sys_rst) return;
        set_exp(1'b1, fcs[8*k +: 8], 1'b0);
      end
`else
      fcs = crc;
`endif
      // First edge only retires the last valid byte, then IFG_N idle cycles.
      gap = int'(IFG_N) + 1;
    end
    repeat (gap) begin
      @(posedge gmii_gtx_clk);
      if (sys_rst) return;
      set_exp(1'b0, 8'h00, 1'b0);
    end
  endtask

  initial begin : model
    forever begin
      m_pop = 1'b0;
      set_exp(1'b0, 8'h00, 1'b0);
      model_frame();
    end
  end

  // ---------------- stimulus / compare helpers ----------------
  task automatic refresh();
    frm_empty = stall || (q_data.size() == 0);
    frm_dout  = frm_empty ? 8'h00 : q_data[0];
    frm_last  = frm_empty ? 1'b0 : q_last[0];
  endtask

  task automatic push_byte(input logic [7:0] b, input bit last);
    q_data.push_back(b);
    q_last.push_back(last);
  endtask

  task automatic clear_mon();
    cap.delete();
    gaps.delete();
    low_run   = 0;
    seen_high = 1'b0;
    und_cnt   = 0;
  endtask

  task automatic lit_check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_cycle();
    logic       e_dv, e_und, e_rd;
    logic [7:0] e_din;
    if (sys_rst) begin
      e_dv = 1'b0; e_din = 8'h00; e_und = 1'b0; e_rd = 1'b0;
    end else begin
      e_dv = exp_dv; e_din = exp_din; e_und = exp_und; e_rd = m_pop && !frm_empty;
    end
    tests++;
    if (fifo_dv !== e_dv || fifo_din !== e_din || tx_underrun !== e_und || frm_rd_en !== e_rd) begin
      fails++;
      $display("FAIL cycle t=%0t: got dv=%b din=%h und=%b rd=%b, required dv=%b din=%h und=%b rd=%b",
               $time, fifo_dv, fifo_din, tx_underrun, frm_rd_en, e_dv, e_din, e_und, e_rd);
    end
    if (!sys_rst) begin
      if (fifo_dv) begin
        cap.push_back(fifo_din);
        if (seen_high && low_run > 0) gaps.push_back(low_run);
        seen_high = 1'b1;
        low_run   = 0;
      end else begin
        low_run++;
      end
      if (tx_underrun) und_cnt++;
    end
  endtask

  task automatic tick(input int n);
    bit pop_req;
    repeat (n) begin
      @(negedge gmii_gtx_clk);
      check_cycle();
      pop_req = frm_rd_en && !frm_empty;
      @(posedge gmii_gtx_clk);
      #1;
      if (pop_req && q_data.size() != 0) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      refresh();
    end
  endtask

  // Compares captured dv bytes against preamble, SFD and the given payload.
  task automatic check_frame(input string name, input logic [7:0] pay[$]);
    logic [7:0] want[$];
    for (int i = 0; i < int'(PRE_N); i++) want.push_back(PREAMBLE_BYTE);
    want.push_back(SFD_BYTE);
    foreach (pay[i]) want.push_back(pay[i]);
    for (int i = 0; i < want.size(); i++)
      lit_check($sformatf("%s[%0d]", name, i),
                (i < cap.size()) ? {24'h0, cap[i]} : 32'hFFFF_FFFF, {24'h0, want[i]});
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    logic [7:0] pay[$];
    int len;
    stall = 1'b0;
    clear_mon();
    refresh();

    // Asynchronous reset assertion mid-cycle.
    #2 sys_rst = 1'b1;
    #1 lit_check("reset_async", {21'h0, fifo_dv, fifo_din, tx_underrun, frm_rd_en}, 32'h0);
    tick(3);
    sys_rst = 1'b0;
    tick(2);

    // Model pin: CRC-32 of "123456789".
    begin
      logic [31:0] c;
      c = CRC32_INIT;
      for (int i = 0; i < 9; i++) c = crc_byte(c, 8'(8'h31 + i));
      lit_check("crc_model", ~c, 32'hCBF43926);
    end

    // Basic 3-byte frame.
    clear_mon();
    push_byte(8'hAA, 0); push_byte(8'hBB, 0); push_byte(8'hCC, 1);
    refresh();
    tick(40);
    pay = '{8'hAA, 8'hBB, 8'hCC};
    check_frame("basic", pay);
`ifdef GMII_TX_FCS_EN
    lit_check("basic_len", cap.size(), 15);
`else
    lit_check("basic_len", cap.size(), 11);
`endif

    // Back-to-back 2-byte frames.
    clear_mon();
    push_byte(8'h11, 0); push_byte(8'h22, 1);
    push_byte(8'h33, 0); push_byte(8'h44, 1);
    refresh();
    tick(70);
    lit_check("b2b_gap_count", gaps.size(), 1);
    lit_check("b2b_gap_len", (gaps.size() > 0) ? gaps[0] : -1, 13);

    // Underrun after byte 2, remainder arrives 5 cycles later.
    clear_mon();
    push_byte(8'h01, 0); push_byte(8'h02, 0);
    refresh();
    for (int i = 0; i < 40 && q_data.size() != 0; i++) tick(1);
    tick(5);
    push_byte(8'h03, 0); push_byte(8'h04, 1);
    refresh();
    tick(30);
    lit_check("underrun_pulses", und_cnt, 1);
    lit_check("underrun_len", cap.size(), 10);
    lit_check("underrun_drained", q_data.size(), 0);
    pay = '{8'h01, 8'h02};
    check_frame("underrun", pay);
    clear_mon();
    push_byte(8'h5A, 0); push_byte(8'hA5, 0); push_byte(8'h3C, 1);
    refresh();
    tick(40);
    pay = '{8'h5A, 8'hA5, 8'h3C};
    check_frame("after_underrun", pay);

    // Reset while the payload is being sent.
    push_byte(8'h10, 0); push_byte(8'h20, 0); push_byte(8'h30, 0);
    push_byte(8'h40, 0); push_byte(8'h50, 0); push_byte(8'h60, 1);
    refresh();
    tick(int'(PRE_N) + 4);
    #1 sys_rst = 1'b1;
    #1 lit_check("reset_midframe", {21'h0, fifo_dv, fifo_din, tx_underrun, frm_rd_en}, 32'h0);
    q_data.delete(); q_last.delete();
    refresh();
    tick(3);
    sys_rst = 1'b0;
    tick(2);
    clear_mon();
    push_byte(8'hE1, 0); push_byte(8'hE2, 1);
    refresh();
    tick(40);
    pay = '{8'hE1, 8'hE2};
    check_frame("restart", pay);

`ifdef GMII_TX_FCS_EN
    // FCS over "123456789".
    clear_mon();
    for (int i = 0; i < 9; i++) push_byte(8'(8'h31 + i), i == 8);
    refresh();
    tick(50);
    lit_check("fcs_len", cap.size(), 21);
    lit_check("fcs_bytes", (cap.size() == 21) ? {cap[17], cap[18], cap[19], cap[20]} : 32'h0,
              32'h2639F4CB);
`endif

    // Random frames with random FIFO stalls (some causing underruns).
    for (int f = 0; f < 25; f++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) push_byte(8'($urandom), i == len - 1);
    end
    for (int i = 0; i < 1200; i++) begin
      stall = ($urandom_range(0, 15) == 0);
      refresh();
      tick(1);
    end
    stall = 1'b0;
    refresh();
    for (int i = 0; i < 600 && q_data.size() != 0; i++) tick(1);
    lit_check("random_drained", q_data.size(), 0);
    tick(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Frame-level transmit stage directly upstream of the GMII output register stage.
- Pops bytes of complete frames from a first-word-fall-through frame FIFO.
- Emits each frame as preamble, SFD, payload and optional FCS on fifo_dv/fifo_din, then enforces the inter-frame gap.
- Handles FIFO underrun mid-frame by truncating the frame and discarding the remainder.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (range 1..15).
- IFG_BYTES, 12, idle cycles (fifo_dv=0) enforced after every frame end, including truncated frames (range 1..255).

Ports:
- gmii_gtx_clk  in  1  125 MHz transmit clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- frm_empty  in  1  frame FIFO empty; when 0, frm_dout and frm_last are valid (FWFT).
- frm_dout  in  8  frame FIFO data byte.
- frm_last  in  1  marks frm_dout as the final payload byte of a frame.
- frm_rd_en  out  1  combinational pop; the FIFO advances on the edge where frm_rd_en=1.
- fifo_dv  out  1  registered byte-valid to the GMII output stage.
- fifo_din  out  8  registered byte to the GMII output stage.
- tx_underrun  out  1  registered one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, fifo_dv=0, fifo_din=8'h00, tx_underrun=0, all counters 0.
  - frm_rd_en=0 while in reset.
- fifo_din is 8'h00 whenever fifo_dv=0.
- All outputs except frm_rd_en are registered. frm_rd_en is a function of state and frm_empty only.
- IDLE:
  - If frm_empty=0 at an edge: go to PRE and register fifo_dv=1, fifo_din=0x55. The first preamble byte is visible one cycle after the start condition.
  - No pop in IDLE.
- PRE: emit 0x55 until PREAMBLE_LEN bytes total have been sent, then register 0xD5 (SFD) and go to DATA.
- DATA:
  - frm_rd_en = !frm_empty.
  - On each pop, register fifo_dv=1, fifo_din=frm_dout.
  - If frm_last was popped: go to FCS if the optional feature is enabled, else to IFG.
  - If frm_empty=1 in DATA (underrun): register fifo_dv=0, pulse tx_underrun, go to DROP.
- DROP:
  - frm_rd_en = !frm_empty; popped bytes are discarded and fifo_dv stays 0.
  - Popping a byte with frm_last=1 goes to IFG.
- IFG:
  - fifo_dv=0 for exactly IFG_BYTES cycles, counted from the first cycle with fifo_dv=0 after the frame; then IDLE.
  - The FIFO is not examined during IFG.
- Minimum spacing between the last valid byte of frame N and the first 0x55 of frame N+1 is IFG_BYTES+1 idle cycles (IFG, then the IDLE decision cycle).
- Single-byte frames (frm_last on the first payload byte) are legal.
- No payload length checks or padding; upstream guarantees ≥1 byte per frame.

Optional Feature:
- Macro: GMII_TX_FCS_EN.
- Defined:
  - CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) accumulates over every payload byte emitted in DATA. Preamble and SFD are excluded.
  - After the last payload byte, state FCS emits four bytes of ~crc, LSB byte first, with fifo_dv=1, then goes to IFG.
  - The CRC is re-initialised on entry to PRE.
  - Truncated frames emit no FCS.
- Undefined: no FCS state and no CRC logic; the frame ends at the last payload byte.

Decomposition:
- Package gmii_pkg holds:
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF.
  - State encoding IDLE/PRE/DATA/FCS/IFG/DROP.
- One sub-module, crc32_d8: combinational next-CRC over one byte (crc_in[31:0], d[7:0] -> crc_out[31:0]). Instantiated only under GMII_TX_FCS_EN.

Test Plan:
- Reset value check: assert sys_rst asynchronously mid-cycle -> fifo_dv=0, fifo_din=00, tx_underrun=0 immediately, without waiting for a clock edge.
- Basic frame: preload frame {0xAA,0xBB,0xCC(last)}, FCS off -> fifo_dv high 11 cycles with bytes 55×7, D5, AA, BB, CC, then dv low.
- Back-to-back: two 2-byte frames preloaded -> exactly 13 dv-low cycles between CC of frame 1 and first 55 of frame 2; frm_rd_en never high in PRE, IFG or IDLE.
- Underrun:
  - Stimulus: frame of 4 bytes, FIFO goes empty after byte 2 for 5 cycles, then bytes 3 and 4 (last) arrive.
  - Response: dv drops after byte 2; tx_underrun high one cycle; bytes 3 and 4 popped without dv; 12-cycle gap counted; next frame is normal.
- Reset mid-frame: assert sys_rst during DATA -> outputs at reset values; after release, the next non-empty FIFO starts a fresh preamble.
- FCS (GMII_TX_FCS_EN): payload ASCII "123456789" -> after byte 0x39 the four FCS bytes 26, 39, F4, CB follow with dv=1, then 12-cycle gap.
